dmd_load_arbiter: RTL and testbench

- Shares the single dot-matrix load port (column_id, in_column, LOAD) between three requesters: the input editor (0), the ROM debug viewer (1) and the run-state dump (2).
- Replaces the per-mode divided LOAD clocks with a single-clock request/acknowledge scheduler that produces timed setup/strobe/hold phases.
- Sits between the mode-specific column generators and the Matrix block.

---
 rtl/dmd_load_arbiter_pkg.sv | 34 +++
 rtl/dmd_load_arbiter_if.sv | 36 +++
 rtl/dmd_load_arbiter_rr_pick3.sv | 40 ++++
 rtl/dmd_load_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmd_load_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dmd_load_arbiter_pkg.sv
// Shared definitions for the dot-matrix load-port arbiter.
// Holds the FSM state encoding, requester index constants, default phase
// widths and small helpers used by the arbiter and its round-robin picker.
package dmd_load_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam logic [1:0] ReqInput = 2'd0;
  localparam logic [1:0] ReqDebug = 2'd1;
  localparam logic [1:0] ReqRun   = 2'd2;
  localparam logic [1:0] PrioNone = 2'd3;

  localparam int unsigned DefSetupCyc  = 2;
  localparam int unsigned DefStrobeCyc = 2;
  localparam int unsigned DefHoldCyc   = 1;

  // Next requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= ReqRun) ? ReqInput : idx + 2'd1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dmd_load_arbiter_if.sv
// Bundle of requester-side and Matrix-side signals of the load arbiter.
//   req/col*/data*/prio_en/prio_sel : requests and arbitration control
//   ack/err/grant_id/busy           : per-requester completion status
//   dmd_column_id/dmd_in_column/dmd_load : Matrix load port
// master: requester/Matrix side (drives requests); slave: the arbiter.
interface dmd_load_arbiter_if #(
  parameter int unsigned ColW  = 5,
  parameter int unsigned DataW = 16
);
  logic [2:0]       req;
  logic [ColW-1:0]  col0;
  logic [ColW-1:0]  col1;
  logic [ColW-1:0]  col2;
  logic [DataW-1:0] data0;
  logic [DataW-1:0] data1;
  logic [DataW-1:0] data2;
  logic             prio_en;
  logic [1:0]       prio_sel;
  logic [2:0]       ack;
  logic [2:0]       err;
  logic [ColW-1:0]  dmd_column_id;
  logic [DataW-1:0] dmd_in_column;
  logic             dmd_load;
  logic             busy;
  logic [1:0]       grant_id;

  modport master (
    output req, col0, col1, col2, data0, data1, data2, prio_en, prio_sel,
    input  ack, err, dmd_column_id, dmd_in_column, dmd_load, busy, grant_id
  );

  modport slave (
    input  req, col0, col1, col2, data0, data1, data2, prio_en, prio_sel,
    output ack, err, dmd_column_id, dmd_in_column, dmd_load, busy, grant_id
  );
endinterface

// File: rtl/dmd_load_arbiter_rr_pick3.sv
// Combinational three-way arbiter pick.
//   req_i      : request vector
//   last_i     : last granted index (round-robin pointer)
//   prio_en_i  : enable fixed preference
//   prio_sel_i : preferred index (3 = none)
//   valid_o    : any request present
//   winner_o   : selected requester index
module rr_pick3
  import dmd_load_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  input  logic       prio_en_i,
  input  logic [1:0] prio_sel_i,
  output logic       valid_o,
  output logic [1:0] winner_o
);

  logic [3:0] req_ext;
  logic [1:0] nxt1;
  logic [1:0] nxt2;

  // Pad to four entries so a 2-bit index (including PrioNone) is always in range.
  assign req_ext = {1'b0, req_i};
  assign nxt1    = rr_next(last_i);
  assign nxt2    = rr_next(nxt1);

  always_comb begin
    valid_o  = |req_i;
    winner_o = last_i;
    if (prio_en_i && (prio_sel_i != PrioNone) && req_ext[prio_sel_i]) begin
      winner_o = prio_sel_i;
    end else if (req_ext[nxt1]) begin
      winner_o = nxt1;
    end else if (req_ext[nxt2]) begin
      winner_o = nxt2;
    end
  end

endmodule

// File: rtl/dmd_load_arbiter.sv
// Dot-matrix load-port arbiter: grants one of three requesters, then drives
// the Matrix load port through timed setup / strobe / hold phases.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus_io : requester and Matrix signals (slave modport)
module dmd_load_arbiter
  import dmd_load_arbiter_pkg::*;
#(
  parameter int unsigned ColW      = 5,
  parameter int unsigned DataW     = 16,
  parameter int unsigned NumCols   = 16,
  parameter int unsigned SetupCyc  = DefSetupCyc,
  parameter int unsigned StrobeCyc = DefStrobeCyc,
  parameter int unsigned HoldCyc   = DefHoldCyc
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dmd_load_arbiter_if.slave   bus_io
);

  localparam int unsigned MaxCyc = max3(SetupCyc, StrobeCyc, HoldCyc);
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [2:0]        ack_q, ack_d;
  logic [2:0]        err_q, err_d;

  logic              pick_valid;
  logic [1:0]        pick_id;
  logic [ColW-1:0]   col_sel;
  logic [DataW-1:0]  data_sel;
  logic [CntW-1:0]   phase_last;
  logic              phase_done;

  rr_pick3 u_pick (
    .req_i      (bus_io.req),
    .last_i     (last_q),
    .prio_en_i  (bus_io.prio_en),
    .prio_sel_i (bus_io.prio_sel),
    .valid_o    (pick_valid),
    .winner_o   (pick_id)
  );

  always_comb begin
    col_sel  = bus_io.col0;
    data_sel = bus_io.data0;
    case (pick_id)
      ReqDebug: begin
        col_sel  = bus_io.col1;
        data_sel = bus_io.data1;
      end
      ReqRun: begin
        col_sel  = bus_io.col2;
        data_sel = bus_io.data2;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (state_q)
      StSetup:  phase_last = CntW'(SetupCyc - 1);
      StStrobe: phase_last = CntW'(StrobeCyc - 1);
      StHold:   phase_last = CntW'(HoldCyc - 1);
      StIdle:   phase_last = '0;
    endcase
  end

  assign phase_done = (cnt_q == phase_last);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= ReqRun;  // requester 0 is first in line after reset
      grant_q <= ReqInput;
      col_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      col_q   <= col_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    col_d   = col_q;
    data_d  = data_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_valid) begin
          grant_d = pick_id;
          last_d  = pick_id;
          col_d   = col_sel;
          data_d  = data_sel;
          // Out-of-range column: report and never touch dmd_load.
          if (32'(col_sel) < NumCols) begin
            state_d = StSetup;
          end else begin
            err_d = 3'b001 << pick_id;
          end
        end
      end
      StSetup: begin
        if (phase_done) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (phase_done) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (phase_done) begin
          state_d = StIdle;
          cnt_d   = '0;
          ack_d   = 3'b001 << grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus_io.dmd_load = (state_q == StStrobe);
    bus_io.busy     = (state_q != StIdle);
  end

  assign bus_io.ack           = ack_q;
  assign bus_io.err           = err_q;
  assign bus_io.dmd_column_id = col_q;
  assign bus_io.dmd_in_column = data_q;
  assign bus_io.grant_id      = grant_q;

endmodule

// File: tb/tb_dmd_load_arbiter.sv
// Directed bench for dmd_load_arbiter with hand-computed expectations.
module tb_dmd_load_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dmd_load_arbiter_if #(.ColW(5), .DataW(16)) bus ();

  dmd_load_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: k=1 is the cycle after the grant edge, ack at k=6.
  task automatic xfer(input string name, input logic [1:0] id, input logic [4:0] col,
                      input logic [15:0] data, input bit drop_mid);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk({name, ".grant"}, bus.grant_id, id);
      chk({name, ".col"}, bus.dmd_column_id, col);
      chk({name, ".data"}, bus.dmd_in_column, data);
      chk({name, ".load"}, bus.dmd_load, (k == 3 || k == 4) ? 1 : 0);
      chk({name, ".ack"}, bus.ack, (k == 6) ? (3'b001 << id) : 3'b000);
      chk({name, ".err"}, bus.err, 0);
      chk({name, ".busy"}, bus.busy, (k != 6) ? 1 : 0);
      if (k == 1 && drop_mid) begin
        bus.data1 = 16'hFFFF;
        bus.req   = 3'b000;
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.req      = 3'b000;
    bus.col0     = '0;
    bus.col1     = '0;
    bus.col2     = '0;
    bus.data0    = '0;
    bus.data1    = '0;
    bus.data2    = '0;
    bus.prio_en  = 1'b0;
    bus.prio_sel = 2'd3;

    // Reset values
    repeat (2) tick();
    chk("rst.ack", bus.ack, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.load", bus.dmd_load, 0);
    chk("rst.col", bus.dmd_column_id, 0);
    chk("rst.data", bus.dmd_in_column, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.grant", bus.grant_id, 0);
    rst_n = 1'b1;
    tick();

    // Single transfer from requester 0
    bus.req   = 3'b001;
    bus.col0  = 5'd5;
    bus.data0 = 16'hA5A5;
    xfer("single", 2'd0, 5'd5, 16'hA5A5, 1'b0);
    bus.req = 3'b000;
    tick();
    chk("single.ack_clr", bus.ack, 0);
    chk("single.idle", bus.busy, 0);

    // Round-robin with all three requesting, from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.col0  = 5'd1;
    bus.col1  = 5'd2;
    bus.col2  = 5'd3;
    bus.data0 = 16'h1111;
    bus.data1 = 16'h2222;
    bus.data2 = 16'h3333;
    bus.req   = 3'b111;
    xfer("rr0", 2'd0, 5'd1, 16'h1111, 1'b0);
    xfer("rr1", 2'd1, 5'd2, 16'h2222, 1'b0);
    xfer("rr2", 2'd2, 5'd3, 16'h3333, 1'b0);
    xfer("rr3", 2'd0, 5'd1, 16'h1111, 1'b0);

    // Fixed preference for requester 2, then back to round-robin from last=2
    bus.prio_en  = 1'b1;
    bus.prio_sel = 2'd2;
    xfer("prio0", 2'd2, 5'd3, 16'h3333, 1'b0);
    xfer("prio1", 2'd2, 5'd3, 16'h3333, 1'b0);
    bus.prio_sel = 2'd3;
    xfer("prio_none", 2'd0, 5'd1, 16'h1111, 1'b0);
    bus.req     = 3'b000;
    bus.prio_en = 1'b0;
    tick();
    chk("prio.idle", bus.busy, 0);

    // Rejected column
    bus.col1 = 5'd16;
    bus.req  = 3'b010;
    tick();
    chk("errcol.err", bus.err, 3'b010);
    chk("errcol.ack", bus.ack, 0);
    chk("errcol.busy", bus.busy, 0);
    chk("errcol.load", bus.dmd_load, 0);
    chk("errcol.grant", bus.grant_id, 1);
    chk("errcol.col", bus.dmd_column_id, 16);
    bus.req = 3'b000;
    tick();
    chk("errcol.err_clr", bus.err, 0);
    chk("errcol.ack2", bus.ack, 0);
    chk("errcol.busy2", bus.busy, 0);
    chk("errcol.load2", bus.dmd_load, 0);

    // Reset during STROBE
    bus.col0  = 5'd7;
    bus.data0 = 16'hBEEF;
    bus.req   = 3'b001;
    repeat (3) tick();
    chk("rstmid.load_hi", bus.dmd_load, 1);
    rst_n   = 1'b0;
    bus.req = 3'b000;
    #1;
    chk("rstmid.load_async", bus.dmd_load, 0);
    chk("rstmid.busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid.ack", bus.ack, 0);
    chk("rstmid.err", bus.err, 0);
    chk("rstmid.col", bus.dmd_column_id, 0);
    chk("rstmid.data", bus.dmd_in_column, 0);
    chk("rstmid.grant", bus.grant_id, 0);
    bus.req = 3'b001;
    xfer("rstmid.redo", 2'd0, 5'd7, 16'hBEEF, 1'b0);
    bus.req = 3'b000;
    tick();

    // Input change and req drop after grant
    bus.col1  = 5'd3;
    bus.data1 = 16'h1234;
    bus.req   = 3'b010;
    xfer("hold_in", 2'd1, 5'd3, 16'h1234, 1'b1);
    tick();
    chk("hold_in.ack_clr", bus.ack, 0);
    chk("hold_in.idle", bus.busy, 0);
    chk("hold_in.data_kept", bus.dmd_in_column, 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
